depp_host: RTL

- DEPP (Digilent parallel port) host-side initiator: the other end of the link from the DEPP-to-Wishbone bridge.
- Converts single-byte commands into EPP address/data write/read cycles on the astb_n/dstb_n/write_n/depp/wait interface.
- Used as the bench-side and FPGA-to-FPGA driver for the bridge, with per-cycle timeout reporting.

---
 rtl/depp_host.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/depp_host.sv
// DEPP host-side initiator: turns single-byte commands into EPP address/data
// read/write cycles on astb_n/dstb_n/write_n/depp/wait, with a per-cycle timeout.
module depp_host #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_stb,
    input  logic [1:0] i_cmd_type,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_busy,
    output logic       o_rsp_stb,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_timeout,
    output logic       o_astb_n,
    output logic       o_dstb_n,
    output logic       o_write_n,
    output logic [7:0] o_depp,
    output logic       o_depp_oe,
    input  logic [7:0] i_depp,
    input  logic       i_wait
);

    localparam int SW = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    cmd_type, cmd_type_nxt;
    logic [SW-1:0] setup_cnt, setup_cnt_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]    rd_data, rd_data_nxt;
    logic          wait_meta, wait_s;

    logic          astb_n_nxt, dstb_n_nxt, write_n_nxt, depp_oe_nxt;
    logic [7:0]    depp_nxt;
    logic          cmd_busy_nxt, rsp_stb_nxt, rsp_timeout_nxt;
    logic [7:0]    rsp_data_nxt;
    logic          to_hit;

    assign to_hit = (to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            cmd_type      <= 2'b00;
            setup_cnt     <= '0;
            to_cnt        <= '0;
            rd_data       <= 8'h00;
            wait_meta     <= 1'b0;
            wait_s        <= 1'b0;
            o_astb_n      <= 1'b1;
            o_dstb_n      <= 1'b1;
            o_write_n     <= 1'b1;
            o_depp        <= 8'h00;
            o_depp_oe     <= 1'b0;
            o_cmd_busy    <= 1'b0;
            o_rsp_stb     <= 1'b0;
            o_rsp_data    <= 8'h00;
            o_rsp_timeout <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd_type      <= cmd_type_nxt;
            setup_cnt     <= setup_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            rd_data       <= rd_data_nxt;
            wait_meta     <= i_wait;
            wait_s        <= wait_meta;
            o_astb_n      <= astb_n_nxt;
            o_dstb_n      <= dstb_n_nxt;
            o_write_n     <= write_n_nxt;
            o_depp        <= depp_nxt;
            o_depp_oe     <= depp_oe_nxt;
            o_cmd_busy    <= cmd_busy_nxt;
            o_rsp_stb     <= rsp_stb_nxt;
            o_rsp_data    <= rsp_data_nxt;
            o_rsp_timeout <= rsp_timeout_nxt;
        end
    end

    // Every output is computed here one cycle ahead so the pins come straight from flops.
    always_comb begin
        state_nxt       = state;
        cmd_type_nxt    = cmd_type;
        setup_cnt_nxt   = setup_cnt;
        to_cnt_nxt      = to_cnt;
        rd_data_nxt     = rd_data;
        astb_n_nxt      = o_astb_n;
        dstb_n_nxt      = o_dstb_n;
        write_n_nxt     = o_write_n;
        depp_nxt        = o_depp;
        depp_oe_nxt     = o_depp_oe;
        rsp_stb_nxt     = 1'b0;
        rsp_data_nxt    = o_rsp_data;
        rsp_timeout_nxt = o_rsp_timeout;

        case (state)
            IDLE: begin
                if (i_cmd_stb) begin
                    state_nxt     = SETUP;
                    cmd_type_nxt  = i_cmd_type;
                    setup_cnt_nxt = '0;
                    write_n_nxt   = i_cmd_type[0];
                    if (!i_cmd_type[0]) begin
                        depp_nxt    = i_cmd_data;
                        depp_oe_nxt = 1'b1;
                    end else begin
                        depp_nxt    = 8'h00;
                        depp_oe_nxt = 1'b0;
                    end
                end
            end

            // A peripheral still holding wait from a previous cycle blocks the strobe.
            SETUP: begin
                if (setup_cnt == SETUP_LAST) begin
                    if (!wait_s) begin
                        state_nxt  = STROBE;
                        to_cnt_nxt = '0;
                        if (cmd_type[1]) begin
                            dstb_n_nxt = 1'b0;
                        end else begin
                            astb_n_nxt = 1'b0;
                        end
                    end
                end else begin
                    setup_cnt_nxt = setup_cnt + SW'(1);
                end
            end

            STROBE: begin
                to_cnt_nxt = to_cnt + TW'(1);
                if (to_hit) begin
                    state_nxt       = IDLE;
                    astb_n_nxt      = 1'b1;
                    dstb_n_nxt      = 1'b1;
                    write_n_nxt     = 1'b1;
                    depp_nxt        = 8'h00;
                    depp_oe_nxt     = 1'b0;
                    rsp_stb_nxt     = 1'b1;
                    rsp_data_nxt    = 8'h00;
                    rsp_timeout_nxt = 1'b1;
                end else if (wait_s) begin
                    state_nxt  = RELEASE;
                    astb_n_nxt = 1'b1;
                    dstb_n_nxt = 1'b1;
                    if (cmd_type[0]) begin
                        rd_data_nxt = i_depp;
                    end
                end
            end

            RELEASE: begin
                to_cnt_nxt = to_cnt + TW'(1);
                if (to_hit || !wait_s) begin
                    state_nxt       = IDLE;
                    astb_n_nxt      = 1'b1;
                    dstb_n_nxt      = 1'b1;
                    write_n_nxt     = 1'b1;
                    depp_nxt        = 8'h00;
                    depp_oe_nxt     = 1'b0;
                    rsp_stb_nxt     = 1'b1;
                    rsp_timeout_nxt = to_hit;
                    rsp_data_nxt    = (!to_hit && cmd_type[0]) ? rd_data : 8'h00;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        cmd_busy_nxt = (state_nxt != IDLE);
    end

endmodule
